// File: rtl/ebc_arb_pkg.sv
// Shared types and helpers for the EBC readout arbiters.
//   arb_state_e    : arbiter FSM state (idle / grant outstanding)
//   ARB_MODE_*     : values of the runtime mode select
//   onehot2bin     : one-hot to binary index, up to ARB_MAX_W lines
package ebc_arb_pkg;

  typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_state_e;

  localparam logic ARB_MODE_RR    = 1'b0;
  localparam logic ARB_MODE_FIXED = 1'b1;

  // Widest requester vector the helper supports; callers zero-extend.
  localparam int ARB_MAX_W  = 64;
  localparam int ARB_MAX_AW = 6;

  // OR of the indices of all set bits; exact for a one-hot or zero input.
  function automatic logic [ARB_MAX_AW-1:0] onehot2bin(input logic [ARB_MAX_W-1:0] oh);
    logic [ARB_MAX_AW-1:0] b;
    b = '0;
    for (int i = 0; i < ARB_MAX_W; i++) begin
      if (oh[i]) b = b | ARB_MAX_AW'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/rr_group_arbiter_hs_priority_arb.sv
// Combinational lowest-index-first selector.
//   req : request vector
//   gnt : one-hot of the lowest set bit of req (zero when req is zero)
module Priority_arb #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] gnt
);

  // Two's-complement trick: req & -req isolates the lowest set bit.
  assign gnt = req & (~req + 1'b1);

endmodule

// File: rtl/rr_group_arbiter_hs.sv
// Round-robin group arbiter with valid/ready grant handshake for EBC
// pixel-array readout (row or column axis).
//   clk_i, reset_i  : clock (rising edge), async active-high reset
//   enable_i        : arbitration enable; low clears everything next cycle
//   mode_i          : 0 = round-robin group scan, 1 = fixed priority
//   req_i           : level requests, one bit per line
//   gnt_ready_i     : downstream accepts the current grant
//   gnt_valid_o     : grant valid
//   gnt_o, add_o    : one-hot grant and its binary index (zero when invalid)
//   grp_release_o   : one-cycle pulse when a scan group is finished
//   grp_count_o     : grants accepted in the current group (saturating)
module rr_group_arbiter_hs
  import ebc_arb_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = $clog2(WIDTH)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              mode_i,
  input  logic [WIDTH-1:0]  req_i,
  input  logic              gnt_ready_i,
  output logic              gnt_valid_o,
  output logic [WIDTH-1:0]  gnt_o,
  output logic [ADDR_W-1:0] add_o,
  output logic              grp_release_o,
  output logic [ADDR_W:0]   grp_count_o
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [ADDR_W:0]  CNT_MAX  = (ADDR_W+1)'(WIDTH);

  arb_state_e        state, state_nxt;
  logic [WIDTH-1:0]  mask_q, mask_nxt;
  logic              mode_q, mode_nxt;
  logic [WIDTH-1:0]  mreq, pick, rr_mask;
  logic [WIDTH-1:0]  gnt_nxt;
  logic [ADDR_W-1:0] add_nxt, pick_add;
  logic              valid_nxt, release_nxt;
  logic [ADDR_W:0]   count_nxt;

  // Scan window after accepting add_o; widened so add_o=WIDTH-1 shifts
  // everything out instead of wrapping back to bit 0.
  assign rr_mask = ALL_ONES << ({1'b0, add_o} + 1'b1);

  // In GRANT the selector only matters on an accept, so the just-accepted
  // line is always excluded there.
  always_comb begin
    mreq = req_i & mask_q;
    if (state == ARB_GRANT) begin
      if (mode_q == ARB_MODE_FIXED) mreq = req_i & ~gnt_o;
      else                          mreq = req_i & rr_mask & ~gnt_o;
    end
  end

  Priority_arb #(.WIDTH(WIDTH)) u_prio (
    .req (mreq),
    .gnt (pick)
  );

  assign pick_add = ADDR_W'(onehot2bin(ARB_MAX_W'(pick)));

  always_comb begin
    state_nxt   = state;
    mask_nxt    = mask_q;
    mode_nxt    = mode_q;
    gnt_nxt     = gnt_o;
    add_nxt     = add_o;
    valid_nxt   = gnt_valid_o;
    release_nxt = 1'b0;
    count_nxt   = grp_count_o;
    if (!enable_i) begin
      // Abort: silent clear, no release pulse.
      state_nxt = ARB_IDLE;
      mask_nxt  = ALL_ONES;
      gnt_nxt   = '0;
      add_nxt   = '0;
      valid_nxt = 1'b0;
      count_nxt = '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          // Count stays visible through the release pulse, cleared after it.
          if (grp_release_o) count_nxt = '0;
          if (mask_q == ALL_ONES) mode_nxt = mode_i;
          if (|mreq) begin
            gnt_nxt   = pick;
            add_nxt   = pick_add;
            valid_nxt = 1'b1;
            state_nxt = ARB_GRANT;
          end else if (mask_q != ALL_ONES) begin
            release_nxt = 1'b1;
            mask_nxt    = ALL_ONES;
            count_nxt   = '0;
          end
        end
        ARB_GRANT: begin
          if (gnt_ready_i) begin
            if (grp_count_o < CNT_MAX) count_nxt = grp_count_o + 1'b1;
            if (|mreq) begin
              gnt_nxt  = pick;
              add_nxt  = pick_add;
              mask_nxt = (mode_q == ARB_MODE_FIXED) ? ALL_ONES : rr_mask;
            end else begin
              gnt_nxt     = '0;
              add_nxt     = '0;
              valid_nxt   = 1'b0;
              release_nxt = 1'b1;
              mask_nxt    = ALL_ONES;
              state_nxt   = ARB_IDLE;
            end
          end
        end
        default: state_nxt = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= ARB_IDLE;
      mask_q        <= ALL_ONES;
      mode_q        <= ARB_MODE_RR;
      gnt_o         <= '0;
      add_o         <= '0;
      gnt_valid_o   <= 1'b0;
      grp_release_o <= 1'b0;
      grp_count_o   <= '0;
    end else begin
      state         <= state_nxt;
      mask_q        <= mask_nxt;
      mode_q        <= mode_nxt;
      gnt_o         <= gnt_nxt;
      add_o         <= add_nxt;
      gnt_valid_o   <= valid_nxt;
      grp_release_o <= release_nxt;
      grp_count_o   <= count_nxt;
    end
  end

endmodule

// File: tb/tb_rr_group_arbiter_hs.sv
// Testbench for rr_group_arbiter_hs (WIDTH=8): directed vector table,
// hand-written corner sequences and randomized traffic against a
// behavioural model of the arbitration rules.
module tb_rr_group_arbiter_hs;

  localparam int W  = 8;
  localparam int AW = 3;

  logic          clk;
  logic          reset_i;
  logic          enable;
  logic          mode;
  logic [W-1:0]  req;
  logic          ready;
  logic          gnt_valid;
  logic [W-1:0]  gnt;
  logic [AW-1:0] add;
  logic          grp_release;
  logic [AW:0]   grp_count;

  int checks = 0;
  int errors = 0;

  rr_group_arbiter_hs #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .enable_i      (enable),
    .mode_i        (mode),
    .req_i         (req),
    .gnt_ready_i   (ready),
    .gnt_valid_o   (gnt_valid),
    .gnt_o         (gnt),
    .add_o         (add),
    .grp_release_o (grp_release),
    .grp_count_o   (grp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a group is a scan over line indices starting at
  // m_lo; the current grant is line m_idx while m_busy.
  bit m_busy, m_rel, m_mode;
  int m_idx, m_lo, m_cnt;

  function automatic int first_req(input logic [W-1:0] r, input int from, input int skip);
    for (int i = from; i < W; i++) begin
      if (r[i] && i != skip) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_rel = 0; m_mode = 0; m_idx = 0; m_lo = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    int f;
    int start;
    bit rel_old;
    rel_old = m_rel;
    m_rel   = 0;
    if (!enable) begin
      m_busy = 0; m_idx = 0; m_lo = 0; m_cnt = 0;
    end else if (!m_busy) begin
      if (m_lo == 0) m_mode = mode;
      if (rel_old) m_cnt = 0;
      f = first_req(req, m_lo, -1);
      if (f >= 0) begin
        m_busy = 1; m_idx = f;
      end else if (m_lo != 0) begin
        m_rel = 1; m_lo = 0; m_cnt = 0;
      end
    end else if (ready) begin
      if (m_cnt < W) m_cnt++;
      start = m_mode ? 0 : m_idx + 1;
      f = first_req(req, start, m_idx);
      if (f >= 0) begin
        m_lo = start; m_idx = f;
      end else begin
        m_busy = 0; m_idx = 0; m_lo = 0; m_rel = 1;
      end
    end
  endtask

  task automatic check_model();
    logic [W-1:0] eg;
    eg = m_busy ? (W'(1) << m_idx) : '0;
    chk("model_valid", gnt_valid, m_busy);
    chk("model_gnt", gnt, eg);
    chk("model_add", add, m_busy ? m_idx : 0);
    chk("model_release", grp_release, m_rel);
    chk("model_count", grp_count, m_cnt);
  endtask

  task automatic check_invariants();
    int ix;
    ix = 0;
    for (int i = 0; i < W; i++) if (gnt[i]) ix = i;
    chk("onehot0_gnt", $onehot0(gnt), 1);
    chk("gnt_zero_iff_invalid", (gnt == '0), !gnt_valid);
    chk("add_matches_gnt", add, ix);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
    check_invariants();
  endtask

  typedef struct {
    logic          en;
    logic          md;
    logic [W-1:0]  rq;
    logic          rdy;
    logic          ev;
    logic [AW-1:0] ea;
    logic          er;
    logic [AW:0]   ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic en, input logic md, input logic [W-1:0] rq,
                              input logic rdy, input logic ev, input logic [AW-1:0] ea,
                              input logic er, input logic [AW:0] ec);
    vec_t v;
    v.en = en; v.md = md; v.rq = rq; v.rdy = rdy;
    v.ev = ev; v.ea = ea; v.er = er; v.ec = ec;
    return v;
  endfunction

  initial begin
    // en md  req    rdy  valid add rel cnt   (expected after the edge)
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0));
    // RR scan of A5: 0,2,5,7 then release, then new group at 0
    tbl.push_back(mk(1, 0, 8'hA5, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'hA5, 1, 1, 2, 0, 1));
    tbl.push_back(mk(1, 0, 8'hA5, 1, 1, 5, 0, 2));
    tbl.push_back(mk(1, 0, 8'hA5, 1, 1, 7, 0, 3));
    tbl.push_back(mk(1, 0, 8'hA5, 1, 0, 0, 1, 4));
    tbl.push_back(mk(1, 0, 8'hA5, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'hA5, 0, 0, 0, 0, 0));
    // Backpressure: grant on line 4 held while request drops
    tbl.push_back(mk(1, 0, 8'h10, 0, 1, 4, 0, 0));
    tbl.push_back(mk(1, 0, 8'h10, 0, 1, 4, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 4, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 4, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 4, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 1, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 8'h00, 1, 0, 0, 0, 0));
    // Abort during GRANT, then re-enable without release pulse
    tbl.push_back(mk(1, 0, 8'h08, 0, 1, 3, 0, 0));
    tbl.push_back(mk(0, 0, 8'h08, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h08, 0, 1, 3, 0, 0));
    tbl.push_back(mk(1, 0, 8'h08, 1, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0));
    // Fixed priority with 06: alternate 1,2 with count saturating at 8
    tbl.push_back(mk(1, 1, 8'h06, 1, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 8'h06, 1, 1, 2, 0, 1));
    tbl.push_back(mk(1, 1, 8'h06, 1, 1, 1, 0, 2));
    tbl.push_back(mk(1, 1, 8'h06, 1, 1, 2, 0, 3));
    tbl.push_back(mk(1, 1, 8'h06, 1, 1, 1, 0, 4));
    tbl.push_back(mk(1, 1, 8'h06, 1, 1, 2, 0, 5));
    tbl.push_back(mk(1, 1, 8'h06, 1, 1, 1, 0, 6));
    tbl.push_back(mk(1, 1, 8'h06, 1, 1, 2, 0, 7));
    tbl.push_back(mk(1, 1, 8'h06, 1, 1, 1, 0, 8));
    tbl.push_back(mk(1, 1, 8'h06, 1, 1, 2, 0, 8));
    tbl.push_back(mk(1, 1, 8'h06, 1, 1, 1, 0, 8));
    tbl.push_back(mk(1, 1, 8'h00, 1, 0, 0, 1, 8));
    tbl.push_back(mk(1, 0, 8'h00, 1, 0, 0, 0, 0));

    model_reset();
    reset_i = 1'b1; enable = 1'b1; mode = 1'b0; req = 8'hFF; ready = 1'b0;

    // Reset held with all requests raised: outputs stay clear
    repeat (2) @(negedge clk);
    chk("rst_valid", gnt_valid, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_add", add, 0);
    chk("rst_release", grp_release, 0);
    chk("rst_count", grp_count, 0);
    reset_i = 1'b0;
    cycle();
    chk("first_grant_valid", gnt_valid, 1);
    chk("first_grant_add", add, 0);

    // Asynchronous reset mid-grant clears without a clock edge
    #2 reset_i = 1'b1;
    #1;
    model_reset();
    chk("async_rst_valid", gnt_valid, 0);
    chk("async_rst_gnt", gnt, 0);
    @(negedge clk);
    reset_i = 1'b0;
    req = 8'h00;

    foreach (tbl[k]) begin
      enable = tbl[k].en; mode = tbl[k].md; req = tbl[k].rq; ready = tbl[k].rdy;
      cycle();
      chk($sformatf("tbl%0d_valid", k), gnt_valid, tbl[k].ev);
      chk($sformatf("tbl%0d_add", k), add, tbl[k].ea);
      chk($sformatf("tbl%0d_gnt", k), gnt, tbl[k].ev ? (W'(1) << tbl[k].ea) : 0);
      chk($sformatf("tbl%0d_release", k), grp_release, tbl[k].er);
      chk($sformatf("tbl%0d_count", k), grp_count, tbl[k].ec);
    end

    // Late low request: raised after the scan passed it, served next group
    enable = 1; mode = 0; req = 8'hA0; ready = 0;
    cycle();
    chk("late_first_add", add, 5);
    ready = 1;
    cycle();
    chk("late_second_add", add, 7);
    req = 8'hA2;
    cycle();
    chk("late_release", grp_release, 1);
    chk("late_release_valid", gnt_valid, 0);
    chk("late_release_count", grp_count, 2);
    cycle();
    chk("late_newgrp_valid", gnt_valid, 1);
    chk("late_newgrp_add", add, 1);
    chk("late_newgrp_release", grp_release, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(3) == 0) begin
        if ($urandom_range(1) == 0) req = W'($urandom);
        else req = W'($urandom) & W'($urandom);
      end
      ready  = ($urandom_range(9) < 7);
      enable = ($urandom_range(31) != 0);
      if ($urandom_range(15) == 0) mode = ~mode;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
